// File: rtl/ray_pkg.sv
// Shared ray types: lane geometry, direction/origin structs and pack/unpack helpers.
package ray_pkg;

  localparam int RAY_WIDTH = 32;
  localparam int RAY_LANES = 3;

  typedef struct packed {
    logic [RAY_WIDTH-1:0] z;
    logic [RAY_WIDTH-1:0] y;
    logic [RAY_WIDTH-1:0] x;
  } RayDirection;

  typedef struct packed {
    logic [RAY_WIDTH-1:0] z;
    logic [RAY_WIDTH-1:0] y;
    logic [RAY_WIDTH-1:0] x;
  } RayOrigin;

  // Lane 0 = x, lane 1 = y, lane 2 = z.
  function automatic logic [RAY_LANES*RAY_WIDTH-1:0] pack_dir(input RayDirection d);
    return {d.z, d.y, d.x};
  endfunction

  function automatic RayDirection unpack_dir(input logic [RAY_LANES*RAY_WIDTH-1:0] v);
    RayDirection d;
    d.x = v[0*RAY_WIDTH +: RAY_WIDTH];
    d.y = v[1*RAY_WIDTH +: RAY_WIDTH];
    d.z = v[2*RAY_WIDTH +: RAY_WIDTH];
    return d;
  endfunction

  function automatic logic [RAY_LANES*RAY_WIDTH-1:0] pack_org(input RayOrigin o);
    return {o.z, o.y, o.x};
  endfunction

  function automatic RayOrigin unpack_org(input logic [RAY_LANES*RAY_WIDTH-1:0] v);
    RayOrigin o;
    o.x = v[0*RAY_WIDTH +: RAY_WIDTH];
    o.y = v[1*RAY_WIDTH +: RAY_WIDTH];
    o.z = v[2*RAY_WIDTH +: RAY_WIDTH];
    return o;
  endfunction

endpackage

// File: rtl/ray_fifo_ctrl.sv
// FIFO control: wrapping pointers, occupancy count, status flags and optional peak
// tracking (peak register present only when RSF_PEAK_EN is defined).
module ray_fifo_ctrl
  import ray_pkg::*;
#(
  parameter int DEPTH       = 20,
  parameter int AFULL_LEVEL = DEPTH - 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          almost_full,
  output logic          overflow,
  output logic [CW-1:0] count,
  output logic [CW-1:0] peak,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic          wr_en
);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic          overflow_q;
  logic          push, pop;

  // Flags come from the registered count only, never from the handshake inputs.
  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign wr_en = push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);
      if (in_valid && !in_ready) overflow_q <= 1'b1;
    end
  end

`ifdef RSF_PEAK_EN
  logic [CW-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (reset)                peak_q <= '0;
    else if (count_d > peak_q) peak_q <= count_d;
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign count    = count_q;
  assign wptr     = wptr_q;
  assign rptr     = rptr_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/ray_stream_fifo.sv
// Multi-lane first-word-fall-through ray FIFO with valid/ready on both sides.
// Define RSF_PEAK_EN to enable the peak-occupancy register.
module ray_stream_fifo
  import ray_pkg::*;
#(
  parameter int WIDTH       = RAY_WIDTH,
  parameter int LANES       = RAY_LANES,
  parameter int DEPTH       = 20,
  parameter int AFULL_LEVEL = DEPTH - 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CW-1:0]          count,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [CW-1:0]          peak
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic          wr_en;

  ray_fifo_ctrl #(
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .almost_full (almost_full),
    .overflow    (overflow),
    .count       (count),
    .peak        (peak),
    .wptr        (wptr),
    .rptr        (rptr),
    .wr_en       (wr_en)
  );

  // One unreset storage array per lane; the head is read combinationally.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    (* ram_style = "distributed" *) logic [WIDTH-1:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) lane_mem[wptr] <= in_data[l*WIDTH +: WIDTH];
    end

    assign out_data[l*WIDTH +: WIDTH] = lane_mem[rptr];
  end

endmodule
